// File: rtl/flash_bus_sync_fifo.sv
// flash_bus_sync_fifo
//   Single-clock synchronous FIFO. It has registered status flags and sticky
//   overflow/underflow error flags. The read mode can be standard (1-cycle
//   read latency) or first-word-fall-through.
//
// Ports
//   i_clk           system clock, all state changes on the rising edge
//   i_rst           synchronous active-high reset
//   i_data          write data
//   i_we            write enable (ignored while full)
//   i_re            read enable (ignored while empty)
//   i_clr_err       clears the sticky error flags (a new error wins)
//   o_data          read data
//   o_full          count == DEPTH
//   o_almost_full   count >= DEPTH - AF_MARGIN
//   o_empty         count == 0
//   o_almost_empty  count <= AE_MARGIN
//   o_count         number of words held, 0..DEPTH
//   o_overflow      sticky: a write was attempted while full
//   o_underflow     sticky: a read was attempted while empty
module flash_bus_sync_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH_LOG2 = 10,
  parameter int AF_MARGIN  = 4,
  parameter int AE_MARGIN  = 4,
  parameter int FWFT       = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_empty,
  output logic                  o_almost_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   AF_LVL   = (DEPTH_LOG2+1)'(DEPTH - AF_MARGIN);
  localparam logic [DEPTH_LOG2:0]   AE_LVL   = (DEPTH_LOG2+1)'(AE_MARGIN);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  // Acceptance is decided from the registered flags only. A write while full
  // is therefore dropped even when a read frees a slot in the same cycle.
  assign wr_ok = i_we & ~o_full;
  assign rd_ok = i_re & ~o_empty;

  always_comb begin
    count_nxt = o_count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = o_count + CNT_ONE;
      2'b01:   count_nxt = o_count - CNT_ONE;
      default: count_nxt = o_count;
    endcase
  end

  // The storage has no reset, so it can map onto block or distributed RAM.
  always_ff @(posedge i_clk) begin
    if (wr_ok && !i_rst)
      mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_full         <= 1'b0;
      o_almost_full  <= 1'b0;
      o_empty        <= 1'b1;
      o_almost_empty <= 1'b1;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      o_count        <= count_nxt;
      o_full         <= (count_nxt == FULL_LVL);
      o_almost_full  <= (count_nxt >= AF_LVL);
      o_empty        <= (count_nxt == '0);
      o_almost_empty <= (count_nxt <= AE_LVL);
      // Set has priority over clear.
      o_overflow     <= (o_overflow  & ~i_clr_err) | (i_we & o_full);
      o_underflow    <= (o_underflow & ~i_clr_err) | (i_re & o_empty);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // The head word is read combinationally from storage. It is valid
      // whenever o_empty is low, because the write edge that fills an empty
      // FIFO is the same edge that clears o_empty.
      assign o_data = mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      always_ff @(posedge i_clk) begin
        if (i_rst)
          data_q <= '0;
        else if (rd_ok)
          data_q <= mem[rd_ptr];
      end
      assign o_data = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_flash_bus_sync_fifo.sv
module tb_flash_bus_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Instance A: default parameters, standard read mode.
  logic         a_rst = 1'b1, a_we = 1'b0, a_re = 1'b0, a_clr = 1'b0;
  logic [127:0] a_din = '0, a_dout;
  logic         a_full, a_af, a_empty, a_ae, a_ovf, a_unf;
  logic [10:0]  a_count;

  // Instance B: depth 4, AF_MARGIN 1, standard read mode.
  logic         b_rst = 1'b1, b_we = 1'b0, b_re = 1'b0, b_clr = 1'b0;
  logic [7:0]   b_din = '0, b_dout;
  logic         b_full, b_af, b_empty, b_ae, b_ovf, b_unf;
  logic [2:0]   b_count;

  // Instance C: depth 4, first-word-fall-through.
  logic         c_rst = 1'b1, c_we = 1'b0, c_re = 1'b0, c_clr = 1'b0;
  logic [7:0]   c_din = '0, c_dout;
  logic         c_full, c_af, c_empty, c_ae, c_ovf, c_unf;
  logic [2:0]   c_count;

  flash_bus_sync_fifo u_a (
    .i_clk(clk), .i_rst(a_rst), .i_data(a_din), .i_we(a_we), .i_re(a_re),
    .i_clr_err(a_clr), .o_data(a_dout), .o_full(a_full), .o_almost_full(a_af),
    .o_empty(a_empty), .o_almost_empty(a_ae), .o_count(a_count),
    .o_overflow(a_ovf), .o_underflow(a_unf)
  );

  flash_bus_sync_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(2), .AF_MARGIN(1),
                        .AE_MARGIN(1), .FWFT(0)) u_b (
    .i_clk(clk), .i_rst(b_rst), .i_data(b_din), .i_we(b_we), .i_re(b_re),
    .i_clr_err(b_clr), .o_data(b_dout), .o_full(b_full), .o_almost_full(b_af),
    .o_empty(b_empty), .o_almost_empty(b_ae), .o_count(b_count),
    .o_overflow(b_ovf), .o_underflow(b_unf)
  );

  flash_bus_sync_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(2), .AF_MARGIN(1),
                        .AE_MARGIN(1), .FWFT(1)) u_c (
    .i_clk(clk), .i_rst(c_rst), .i_data(c_din), .i_we(c_we), .i_re(c_re),
    .i_clr_err(c_clr), .o_data(c_dout), .o_full(c_full), .o_almost_full(c_af),
    .o_empty(c_empty), .o_almost_empty(c_ae), .o_count(c_count),
    .o_overflow(c_ovf), .o_underflow(c_unf)
  );

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc();
    // Reset state of all instances
    check_val("a_rst_count", a_count, 0);
    check_val("a_rst_empty", a_empty, 1);
    check_val("a_rst_ae", a_ae, 1);
    check_val("a_rst_full", a_full, 0);
    check_val("a_rst_af", a_af, 0);
    check_val("a_rst_ovf", a_ovf, 0);
    check_val("a_rst_unf", a_unf, 0);
    check_val("a_rst_data", a_dout, 0);
    check_val("b_rst_empty", b_empty, 1);
    check_val("c_rst_empty", c_empty, 1);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // A: write 1..4, then read 4
    a_we = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_din = 128'(i);
      cyc();
      check_val("a_wr_count", a_count, 128'(i));
      check_val("a_wr_empty", a_empty, 0);
    end
    a_we = 1'b0;
    check_val("a_ae_at4", a_ae, 1);
    a_re = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check_val("a_rd_data", a_dout, 128'(i));
      check_val("a_rd_count", a_count, 128'(4 - i));
    end
    a_re = 1'b0;
    check_val("a_end_empty", a_empty, 1);

    // A: read while empty with a simultaneous write
    a_re = 1'b1; a_we = 1'b1; a_din = 128'h77;
    cyc();
    a_re = 1'b0; a_we = 1'b0;
    check_val("a_unf_set", a_unf, 1);
    check_val("a_unf_count", a_count, 1);
    check_val("a_unf_data_hold", a_dout, 4);
    a_clr = 1'b1;
    cyc();
    a_clr = 1'b0;
    check_val("a_unf_clr", a_unf, 0);
    a_re = 1'b1;
    cyc();
    check_val("a_rd77", a_dout, 128'h77);
    // A new underflow in the same cycle as a clear must leave the flag set
    a_clr = 1'b1;
    cyc();
    a_re = 1'b0; a_clr = 1'b0;
    check_val("a_unf_setwins", a_unf, 1);
    check_val("a_unf_data_hold2", a_dout, 128'h77);

    // B: write 5 words into depth 4
    b_we = 1'b1;
    b_din = 8'h11; cyc();
    check_val("b_c1_ae", b_ae, 1);
    check_val("b_c1_af", b_af, 0);
    b_din = 8'h22; cyc();
    check_val("b_c2_ae", b_ae, 0);
    check_val("b_c2_af", b_af, 0);
    b_din = 8'h33; cyc();
    check_val("b_c3_af", b_af, 1);
    check_val("b_c3_full", b_full, 0);
    b_din = 8'h44; cyc();
    check_val("b_c4_full", b_full, 1);
    check_val("b_c4_ovf", b_ovf, 0);
    b_din = 8'h55; cyc();
    b_we = 1'b0;
    check_val("b_ovf", b_ovf, 1);
    check_val("b_ovf_count", b_count, 4);
    b_re = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check_val("b_rd_data", b_dout, 128'(8'h11 * i));
    end
    b_re = 1'b0;
    check_val("b_rd_empty", b_empty, 1);

    // B: hold count at 2 with simultaneous write/read across pointer wrap
    b_we = 1'b1;
    b_din = 8'hA0; cyc();
    b_din = 8'hA1; cyc();
    b_re = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b_din = 8'(8'hA2 + k);
      cyc();
      check_val("b_wrap_data", b_dout, 128'(8'hA0 + k));
      check_val("b_wrap_count", b_count, 2);
    end
    b_re = 1'b0;
    b_din = 8'hEE; cyc();
    b_we = 1'b0;
    check_val("b_pre_rst_count", b_count, 3);
    check_val("b_pre_rst_ovf", b_ovf, 1);

    // B: reset with 3 words held
    b_rst = 1'b1; b_we = 1'b1; b_re = 1'b1;
    cyc();
    b_rst = 1'b0; b_we = 1'b0; b_re = 1'b0;
    check_val("b_rst_count", b_count, 0);
    check_val("b_rst_empty2", b_empty, 1);
    check_val("b_rst_ovf", b_ovf, 0);
    check_val("b_rst_af", b_af, 0);
    check_val("b_rst_data", b_dout, 0);
    b_we = 1'b1; b_din = 8'hC3; cyc();
    b_we = 1'b0; b_re = 1'b1; cyc();
    b_re = 1'b0;
    check_val("b_new_data", b_dout, 8'hC3);
    check_val("b_new_empty", b_empty, 1);

    // C: first-word-fall-through
    c_we = 1'b1; c_din = 8'hA5; cyc();
    check_val("c_empty", c_empty, 0);
    check_val("c_head", c_dout, 8'hA5);
    c_din = 8'hB1; cyc();
    c_din = 8'hB2; cyc();
    c_we = 1'b0;
    check_val("c_count3", c_count, 3);
    check_val("c_head_hold", c_dout, 8'hA5);
    c_re = 1'b1;
    cyc();
    check_val("c_rd1", c_dout, 8'hB1);
    check_val("c_rd1_count", c_count, 2);
    cyc();
    check_val("c_rd2", c_dout, 8'hB2);
    cyc();
    c_re = 1'b0;
    check_val("c_rd3_empty", c_empty, 1);
    check_val("c_rd3_count", c_count, 0);
    check_val("c_unf", c_unf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
